fetch_sequencer: RTL and testbench

Instruction-fetch controller that sits directly upstream of the 8-bit program-counter register. It reads the current PC and fetches the instruction from instruction memory over a req/ack handshake. It presents the instruction to decode over a valid/ready handshake. It drives the PC register's `inc`, `write_en` and `datain` controls for sequential advance and branch redirect.

---
 rtl/fetch_sequencer.sv | 112 +++++++++++
 tb/tb_fetch_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch controller between the PC register, imem and decode
module fetch_sequencer #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          halt,
  input  logic [AW-1:0] pc_in,
  output logic          pc_inc,
  output logic          pc_write_en,
  output logic [AW-1:0] pc_datain,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] instr,
  output logic [AW-1:0] instr_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  output logic          busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_REDIRECT,
    S_DRAIN
  } state_t;

  state_t state;
  state_t next_state;
  logic   go;

  assign go = en && !halt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (br_taken)  next_state = S_REDIRECT;
        else if (go)   next_state = S_ISSUE;
      end
      S_ISSUE: begin
        next_state = br_taken ? S_REDIRECT : S_WAIT;
      end
      S_WAIT: begin
        if (br_taken && imem_ack) next_state = S_REDIRECT;
        else if (br_taken)        next_state = S_DRAIN;
        else if (imem_ack)        next_state = S_HOLD;
      end
      S_HOLD: begin
        if (br_taken)         next_state = S_REDIRECT;
        else if (instr_ready) next_state = go ? S_ISSUE : S_IDLE;
      end
      S_REDIRECT: begin
        if (br_taken) next_state = S_REDIRECT;
        else          next_state = go ? S_ISSUE : S_IDLE;
      end
      S_DRAIN: begin
        // A redirect landing with the ack still needs a write before ISSUE may sample pc_in.
        if (br_taken && imem_ack) next_state = S_REDIRECT;
        else if (br_taken)        next_state = S_DRAIN;
        else if (imem_ack)        next_state = go ? S_ISSUE : S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_inc      <= 1'b0;
      pc_write_en <= 1'b0;
      pc_datain   <= '0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_pc    <= '0;
    end else begin
      pc_inc      <= (state == S_WAIT) && (next_state == S_HOLD);
      // Every state answers br_taken by moving to REDIRECT or DRAIN, both of which write the PC.
      pc_write_en <= br_taken;
      if (br_taken) begin
        pc_datain <= br_target;
      end
      if (state == S_ISSUE) begin
        imem_addr <= pc_in;
      end
      if ((state == S_WAIT) && imem_ack && !br_taken) begin
        instr    <= imem_rdata;
        instr_pc <= imem_addr;
      end
    end
  end

  assign imem_req    = (state == S_WAIT) || (state == S_DRAIN);
  assign instr_valid = (state == S_HOLD);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - vector-table and sequence bench for fetch_sequencer
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       halt;
  logic [7:0] pc_in;
  logic       pc_inc;
  logic       pc_write_en;
  logic [7:0] pc_datain;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_ack;
  logic [7:0] imem_rdata;
  logic [7:0] instr;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       br_taken;
  logic [7:0] br_target;
  logic       busy;

  fetch_sequencer #(.AW(8), .DW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .halt        (halt),
    .pc_in       (pc_in),
    .pc_inc      (pc_inc),
    .pc_write_en (pc_write_en),
    .pc_datain   (pc_datain),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, halt;
    logic [7:0] pc;
    logic       ack;
    logic [7:0] rdata;
    logic       rdy, br;
    logic [7:0] tgt;
    logic       busy, req;
    logic [7:0] addr;
    logic       vld;
    logic [7:0] ins, ipc;
    logic       inc, we;
    logic [7:0] din;
  } vec_t;

  vec_t       tv[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] pc_m = 8'h00;
  int         mem_wait = 0;
  int         wait_cnt = 0;

  function automatic vec_t mk(input int rst, en, hlt, pc, ack, rd, rdy, br, tgt,
                              input int bsy, req, addr, vld, ins, ipc, inc, we, din);
    vec_t r;
    r.rst = rst[0];  r.en = en[0];    r.halt = hlt[0];  r.pc = pc[7:0];
    r.ack = ack[0];  r.rdata = rd[7:0]; r.rdy = rdy[0]; r.br = br[0];
    r.tgt = tgt[7:0]; r.busy = bsy[0]; r.req = req[0];  r.addr = addr[7:0];
    r.vld = vld[0];  r.ins = ins[7:0]; r.ipc = ipc[7:0]; r.inc = inc[0];
    r.we = we[0];    r.din = din[7:0];
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Behavioural PC register (write beats inc) and memory returning addr+0x10 after mem_wait cycles.
  task automatic env_cycle();
    logic       s_we, s_inc;
    logic [7:0] s_din;
    pc_in = pc_m;
    if (imem_req) begin
      if (wait_cnt >= mem_wait) begin
        imem_ack = 1'b1;
        wait_cnt = 0;
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
    imem_rdata = imem_addr + 8'h10;
    s_we  = pc_write_en;
    s_inc = pc_inc;
    s_din = pc_datain;
    @(posedge clk);
    #1;
    if (s_we)       pc_m = s_din;
    else if (s_inc) pc_m = pc_m + 8'h01;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; halt = 1'b0; instr_ready = 1'b0;
    br_taken = 1'b0; br_target = 8'h00;
    env_cycle();
    reset = 1'b0;
  endtask

  initial begin
    int n_got, n_inc, last_c, req_cycles, bad, held_bad;
    logic [7:0] a0;
    logic first, got_ff, seen;

    reset = 1'b0; en = 1'b0; halt = 1'b0; pc_in = 8'h00; imem_ack = 1'b0;
    imem_rdata = 8'h00; instr_ready = 1'b0; br_taken = 1'b0; br_target = 8'h00;

    //              rst en hlt pc  ack rdata rdy br tgt   | busy req addr vld instr ipc inc we din
    tv.push_back(mk(1,0,0,'h00,0,'h00,0,0,'h00, 0,0,'h00,0,'h00,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h00,0,'h00,0,0,'h00, 1,0,'h00,0,'h00,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h00,0,'h00,0,0,'h00, 1,1,'h00,0,'h00,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h00,1,'h10,0,0,'h00, 1,0,'h00,1,'h10,'h00,1,0,'h00));
    tv.push_back(mk(0,1,0,'h01,0,'h00,1,0,'h00, 1,0,'h00,0,'h10,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h01,0,'h00,0,0,'h00, 1,1,'h01,0,'h10,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h01,0,'h00,0,0,'h00, 1,1,'h01,0,'h10,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h01,0,'h00,0,0,'h00, 1,1,'h01,0,'h10,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h01,1,'h11,0,0,'h00, 1,0,'h01,1,'h11,'h01,1,0,'h00));
    tv.push_back(mk(0,1,0,'h02,0,'h00,0,0,'h00, 1,0,'h01,1,'h11,'h01,0,0,'h00));
    tv.push_back(mk(0,1,0,'h02,0,'h00,0,0,'h00, 1,0,'h01,1,'h11,'h01,0,0,'h00));
    tv.push_back(mk(0,1,1,'h02,0,'h00,1,0,'h00, 0,0,'h01,0,'h11,'h01,0,0,'h00));
    tv.push_back(mk(0,1,1,'h02,0,'h00,0,0,'h00, 0,0,'h01,0,'h11,'h01,0,0,'h00));
    tv.push_back(mk(0,0,0,'h02,0,'h00,0,1,'h40, 1,0,'h01,0,'h11,'h01,0,1,'h40));
    tv.push_back(mk(0,1,0,'h40,0,'h00,0,0,'h00, 1,0,'h01,0,'h11,'h01,0,0,'h40));
    tv.push_back(mk(0,1,0,'h40,0,'h00,0,0,'h00, 1,1,'h40,0,'h11,'h01,0,0,'h40));
    tv.push_back(mk(0,1,0,'h40,0,'h00,0,1,'h80, 1,1,'h40,0,'h11,'h01,0,1,'h80));
    tv.push_back(mk(0,1,0,'h80,0,'h00,0,1,'h84, 1,1,'h40,0,'h11,'h01,0,1,'h84));
    tv.push_back(mk(0,1,0,'h84,1,'hAA,0,0,'h00, 1,0,'h40,0,'h11,'h01,0,0,'h84));
    tv.push_back(mk(0,1,0,'h84,0,'h00,0,0,'h00, 1,1,'h84,0,'h11,'h01,0,0,'h84));
    tv.push_back(mk(0,1,0,'h84,1,'hBB,0,1,'hC0, 1,0,'h84,0,'h11,'h01,0,1,'hC0));
    tv.push_back(mk(0,1,0,'hC0,0,'h00,0,1,'hC4, 1,0,'h84,0,'h11,'h01,0,1,'hC4));
    tv.push_back(mk(0,1,0,'hC4,0,'h00,0,0,'h00, 1,0,'h84,0,'h11,'h01,0,0,'hC4));
    tv.push_back(mk(0,1,0,'hC4,0,'h00,0,0,'h00, 1,1,'hC4,0,'h11,'h01,0,0,'hC4));
    tv.push_back(mk(0,1,0,'hC4,1,'hCC,0,0,'h00, 1,0,'hC4,1,'hCC,'hC4,1,0,'hC4));
    tv.push_back(mk(0,1,0,'hC5,0,'h00,1,1,'h20, 1,0,'hC4,0,'hCC,'hC4,0,1,'h20));
    tv.push_back(mk(0,1,0,'h20,0,'h00,0,0,'h00, 1,0,'hC4,0,'hCC,'hC4,0,0,'h20));
    tv.push_back(mk(0,1,0,'h20,0,'h00,0,0,'h00, 1,1,'h20,0,'hCC,'hC4,0,0,'h20));
    tv.push_back(mk(0,1,0,'h20,1,'h30,0,0,'h00, 1,0,'h20,1,'h30,'h20,1,0,'h20));
    tv.push_back(mk(1,1,0,'h21,0,'h00,0,0,'h00, 0,0,'h00,0,'h00,'h00,0,0,'h00));
    tv.push_back(mk(0,0,0,'h21,0,'h00,0,0,'h00, 0,0,'h00,0,'h00,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h21,0,'h00,0,0,'h00, 1,0,'h00,0,'h00,'h00,0,0,'h00));
    tv.push_back(mk(0,1,0,'h21,0,'h00,0,1,'h55, 1,0,'h21,0,'h00,'h00,0,1,'h55));
    tv.push_back(mk(0,0,0,'h55,0,'h00,0,0,'h00, 0,0,'h21,0,'h00,'h00,0,0,'h55));

    for (int i = 0; i < tv.size(); i++) begin
      reset = tv[i].rst; en = tv[i].en; halt = tv[i].halt; pc_in = tv[i].pc;
      imem_ack = tv[i].ack; imem_rdata = tv[i].rdata; instr_ready = tv[i].rdy;
      br_taken = tv[i].br; br_target = tv[i].tgt;
      @(posedge clk);
      #1;
      check($sformatf("v%0d.busy", i),  busy,        tv[i].busy);
      check($sformatf("v%0d.req", i),   imem_req,    tv[i].req);
      check($sformatf("v%0d.addr", i),  imem_addr,   tv[i].addr);
      check($sformatf("v%0d.valid", i), instr_valid, tv[i].vld);
      check($sformatf("v%0d.instr", i), instr,       tv[i].ins);
      check($sformatf("v%0d.ipc", i),   instr_pc,    tv[i].ipc);
      check($sformatf("v%0d.inc", i),   pc_inc,      tv[i].inc);
      check($sformatf("v%0d.we", i),    pc_write_en, tv[i].we);
      check($sformatf("v%0d.din", i),   pc_datain,   tv[i].din);
    end

    // Sequential fetch, zero-wait memory, decode always ready.
    do_reset();
    pc_m = 8'h00; mem_wait = 0; en = 1'b1; instr_ready = 1'b1;
    n_got = 0; n_inc = 0; last_c = 0;
    for (int c = 0; c < 40 && n_got < 4; c++) begin
      env_cycle();
      if (pc_inc) n_inc++;
      if (instr_valid) begin
        check($sformatf("seq.instr%0d", n_got), instr, 8'h10 + n_got);
        check($sformatf("seq.ipc%0d", n_got), instr_pc, n_got);
        if (n_got > 0) check($sformatf("seq.gap%0d", n_got), c - last_c, 3);
        last_c = c;
        n_got++;
      end
    end
    check("seq.count", n_got, 4);
    check("seq.inc_count", n_inc, 4);
    env_cycle();

    // Four wait states, then five cycles of decode backpressure.
    mem_wait = 4; instr_ready = 1'b0;
    n_inc = 0; req_cycles = 0; bad = 0; first = 1'b1; a0 = 8'h00;
    for (int c = 0; c < 30 && !instr_valid; c++) begin
      env_cycle();
      if (pc_inc) n_inc++;
      if (imem_req) begin
        if (first) begin
          a0 = imem_addr;
          first = 1'b0;
        end else if (imem_addr !== a0) begin
          bad++;
        end
        req_cycles++;
      end
    end
    check("wait.addr", a0, 8'h04);
    check("wait.addr_stable", bad, 0);
    check("wait.req_cycles", req_cycles, 5);
    check("wait.valid", instr_valid, 1);
    check("wait.instr", instr, 8'h14);
    held_bad = 0;
    for (int k = 0; k < 5; k++) begin
      env_cycle();
      if (pc_inc) n_inc++;
      if (!instr_valid || instr !== 8'h14 || instr_pc !== 8'h04) held_bad++;
    end
    check("bp.held", held_bad, 0);
    instr_ready = 1'b1;
    env_cycle();
    if (pc_inc) n_inc++;
    check("bp.accepted", instr_valid, 0);
    check("bp.inc_count", n_inc, 1);

    // Halt while fetching 0xFF, then resume across the wrap.
    do_reset();
    pc_m = 8'hFE; mem_wait = 0; en = 1'b1; instr_ready = 1'b1;
    got_ff = 1'b0;
    for (int c = 0; c < 40 && !got_ff; c++) begin
      env_cycle();
      if (imem_req && imem_addr == 8'hFF) halt = 1'b1;
      if (instr_valid && instr_pc == 8'hFF) begin
        got_ff = 1'b1;
        check("halt.instr_ff", instr, 8'h0F);
      end
    end
    check("halt.got_ff", got_ff, 1);
    env_cycle();
    check("halt.busy", busy, 0);
    check("halt.valid", instr_valid, 0);
    for (int k = 0; k < 3; k++) env_cycle();
    check("halt.busy_idle", busy, 0);
    check("halt.pc_wrapped", pc_m, 8'h00);
    halt = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      env_cycle();
      if (imem_req) seen = 1'b1;
    end
    check("wrap.req_seen", seen, 1);
    check("wrap.addr", imem_addr, 8'h00);

    // Reset with a request outstanding, then restart from the current PC.
    reset = 1'b1;
    env_cycle();
    reset = 1'b0;
    check("rst.req", imem_req, 0);
    check("rst.busy", busy, 0);
    check("rst.addr", imem_addr, 8'h00);
    check("rst.instr", instr, 8'h00);
    check("rst.we", pc_write_en, 0);
    pc_m = 8'h5A;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      env_cycle();
      if (instr_valid) seen = 1'b1;
    end
    check("rst.restart_valid", seen, 1);
    check("rst.restart_instr", instr, 8'h6A);
    check("rst.restart_ipc", instr_pc, 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
